// File: rtl/div_pkg.sv
// Shared constants for the divider's serial receive path: FSM encodings and default word width.
// Frame length depends on PARITY_CHECK_EN (a trailing even-parity bit extends each frame by one).
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Number of serial bits that make up one frame on bit_in.
  function automatic int frame_bits(input int width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out handshake bundle for serial_word_collector.
// PARITY_CHECK_EN adds the parity_err status line.
interface serial_word_collector_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

`ifdef PARITY_CHECK_EN
  modport slave (
    input  start, bit_in, bit_valid, word_ready,
    output word_out, word_valid, busy, overrun, parity_err
  );
  modport master (
    output start, bit_in, bit_valid, word_ready,
    input  word_out, word_valid, busy, overrun, parity_err
  );
`else
  modport slave (
    input  start, bit_in, bit_valid, word_ready,
    output word_out, word_valid, busy, overrun
  );
  modport master (
    output start, bit_in, bit_valid, word_ready,
    input  word_out, word_valid, busy, overrun
  );
`endif

endinterface

// File: rtl/bit_counter.sv
// Up-counter tracking received bits; tc flags that the count equals the programmed limit.
// Updates on the falling clock edge to match the serial receive path.
module bit_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (count_reg == limit);

endmodule

// File: rtl/serial_word_collector.sv
// Rebuilds a WIDTH-bit word from an MSB-first serial stream and offers it on a valid/ready handshake.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and report parity_err.
module serial_word_collector
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  serial_word_collector_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(frame_bits(WIDTH) - 1);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic             word_valid_reg, word_valid_next;
  logic             overrun_reg, overrun_next;
  logic [WIDTH-1:0] shifted;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_last;
`ifdef PARITY_CHECK_EN
  logic             parity_err_reg, parity_err_next;
`endif

  // Incoming bit appended below the bits already collected (MSB-first framing).
  assign shifted = WIDTH'({sr_reg, bus.bit_in});

  bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .limit   (LAST_IDX),
    .tc      (cnt_last)
  );

  always_comb begin
    state_next      = state_reg;
    sr_next         = sr_reg;
    word_next       = word_reg;
    word_valid_next = word_valid_reg;
    overrun_next    = overrun_reg;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_next = parity_err_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next   = S_SHIFT;
          sr_next      = '0;
          cnt_clear    = 1'b1;
          overrun_next = 1'b0;
        end else if (bus.bit_valid) begin
          overrun_next = 1'b1;
        end
      end

      S_SHIFT: begin
        // A start here abandons the partial word; a coincident bit is dropped.
        if (bus.start) begin
          sr_next   = '0;
          cnt_clear = 1'b1;
        end else if (bus.bit_valid) begin
          if (cnt_last) begin
            state_next      = S_DONE;
            word_valid_next = 1'b1;
`ifdef PARITY_CHECK_EN
            word_next       = sr_reg;
            parity_err_next = (^sr_reg) ^ bus.bit_in;
`else
            word_next       = shifted;
`endif
          end else begin
            sr_next = shifted;
            cnt_inc = 1'b1;
          end
        end
      end

      S_DONE: begin
        // The held word is never overwritten: start only counts alongside an accept.
        if (bus.word_ready && bus.start) begin
          state_next      = S_SHIFT;
          word_valid_next = 1'b0;
          sr_next         = '0;
          cnt_clear       = 1'b1;
          overrun_next    = 1'b0;
`ifdef PARITY_CHECK_EN
          parity_err_next = 1'b0;
`endif
        end else begin
          if (bus.bit_valid) begin
            overrun_next = 1'b1;
          end
          if (bus.word_ready) begin
            state_next      = S_IDLE;
            word_valid_next = 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_next = 1'b0;
`endif
          end
        end
      end

      default: begin
        state_next      = S_IDLE;
        word_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      sr_reg         <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sr_reg         <= sr_next;
      word_reg       <= word_next;
      word_valid_reg <= word_valid_next;
      overrun_reg    <= overrun_next;
`ifdef PARITY_CHECK_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign bus.word_out   = word_reg;
  assign bus.word_valid = word_valid_reg;
  assign bus.busy       = (state_reg == S_SHIFT);
  assign bus.overrun    = overrun_reg;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: directed frames then random traffic against a bit-queue model.
// Honours PARITY_CHECK_EN (adds the parity bit to every frame and checks parity_err).
module tb_serial_word_collector;

  localparam int W = 32;
`ifdef PARITY_CHECK_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  serial_word_collector_if #(.WIDTH(W)) bus ();

  serial_word_collector #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;

  // Reference model: a frame is "being collected" or "being held"; bits kept in a queue.
  bit         m_collect;
  bit         m_hold;
  bit         m_bits[$];
  logic [W-1:0] m_word;
  bit         m_ovr;
`ifdef PARITY_CHECK_EN
  bit         m_perr;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w = (w << 1) | W'(m_bits[i]);
    return w;
  endfunction

  task automatic model_reset();
    m_collect = 1'b0;
    m_hold    = 1'b0;
    m_bits.delete();
    m_word    = '0;
    m_ovr     = 1'b0;
`ifdef PARITY_CHECK_EN
    m_perr    = 1'b0;
`endif
  endtask

  task automatic note_accept();
    n_xfer++;
    $display("xfer %0d: word=%08h overrun=%0d", n_xfer, m_word, m_ovr);
  endtask

  task automatic model_step(input bit st, input bit bv, input bit b, input bit rdy);
    if (m_hold) begin
      if (rdy && st) begin
        note_accept();
        m_hold    = 1'b0;
        m_collect = 1'b1;
        m_bits.delete();
        m_ovr     = 1'b0;
`ifdef PARITY_CHECK_EN
        m_perr    = 1'b0;
`endif
      end else begin
        if (bv) m_ovr = 1'b1;
        if (rdy) begin
          note_accept();
          m_hold = 1'b0;
`ifdef PARITY_CHECK_EN
          m_perr = 1'b0;
`endif
        end
      end
    end else if (m_collect) begin
      if (st) begin
        m_bits.delete();
      end else if (bv) begin
        m_bits.push_back(b);
        if (m_bits.size() == NB) begin
          m_word = pack_bits();
`ifdef PARITY_CHECK_EN
          m_perr = (^m_word) ^ m_bits[W];
`endif
          m_hold    = 1'b1;
          m_collect = 1'b0;
        end
      end
    end else begin
      if (st) begin
        m_collect = 1'b1;
        m_bits.delete();
        m_ovr = 1'b0;
      end else if (bv) begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("busy",       bus.busy,       m_collect);
    check("word_valid", bus.word_valid, m_hold);
    check("overrun",    bus.overrun,    m_ovr);
    check("word_out",   bus.word_out,   m_word);
`ifdef PARITY_CHECK_EN
    if (m_hold) check("parity_err", bus.parity_err, m_perr);
`endif
  endtask

  // One falling-edge transaction: inputs set after the rising edge, outputs sampled just after the falling edge.
  task automatic drive(input bit st, input bit bv, input bit b, input bit rdy);
    @(posedge clk);
    bus.start      = st;
    bus.bit_valid  = bv;
    bus.bit_in     = b;
    bus.word_ready = rdy;
    model_step(st, bv, b, rdy);
    @(negedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_word_out",   bus.word_out,   0);
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_busy",       bus.busy,       0);
    check("rst_overrun",    bus.overrun,    0);
`ifdef PARITY_CHECK_EN
    check("rst_parity_err", bus.parity_err, 0);
`endif
    bus.start      = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.word_ready = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b0, 1'b1, w[i], 1'b0);
`ifdef PARITY_CHECK_EN
    drive(1'b0, 1'b1, ^w, 1'b0);
`endif
  endtask

  task automatic accept();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.word_ready = 1'b0;
    model_reset();
    async_reset();

    // Basic frame: valid rises on the last bit edge, busy falls on the same edge.
    send_frame(32'hA5C3_0F81);
    check("t1_word",  bus.word_out,   32'hA5C3_0F81);
    check("t1_valid", bus.word_valid, 1);
    check("t1_busy",  bus.busy,       0);

    // Back-pressure, then a start with no accept must not disturb the held word.
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_hold_word", bus.word_out, 32'hA5C3_0F81);
    check("t2_hold_busy", bus.busy,     0);
    accept();
    check("t2_idle_valid", bus.word_valid, 0);
    check("t2_idle_busy",  bus.busy,       0);

    // Aborted frame followed by a restart.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
    send_frame(32'h0000_0001);
    check("t3_word", bus.word_out, 32'h0000_0001);
    // Accept and start on the same edge go straight into a new frame.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_b2b_busy",  bus.busy,       1);
    check("t3_b2b_valid", bus.word_valid, 0);
    async_reset();

    // Overrun in IDLE, cleared by the next start.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("t4_ovr_set", bus.overrun, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_ovr_clr", bus.overrun, 0);

    // Reset mid-frame, then a clean frame.
    repeat (20) drive(1'b0, 1'b1, 1'($urandom), 1'b0);
    async_reset();
    send_frame(32'hFFFF_FFFF);
    check("t5_word", bus.word_out, 32'hFFFF_FFFF);
    accept();

`ifdef PARITY_CHECK_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b0, 1'b1, 1'((32'h3 >> i) & 1), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_par_ok", bus.parity_err, 0);
    accept();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b0, 1'b1, 1'((32'h3 >> i) & 1), 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_par_bad", bus.parity_err, 1);
    accept();
    check("t6_par_clr", bus.parity_err, 0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        async_reset();
      end else begin
        drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
              1'($urandom), ($urandom_range(0, 99) < 40));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
